// File: rtl/dram_pkg.sv
// dram_pkg: FSM state encoding, strobe decode constants and the in-page column wrap helper
// Latency: none, definitions only
// Backpressure: none, definitions only
package dram_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_PAGE     = 2'd1;
    localparam state_t ST_BURST_RD = 2'd2;
    localparam state_t ST_BURST_WR = 2'd3;

    // Sampled {ras_b, cas_b} pairs; both strobes are active low
    localparam logic [1:0] STB_NONE = 2'b11;
    localparam logic [1:0] STB_RAS  = 2'b01;
    localparam logic [1:0] STB_CAS  = 2'b10;
    localparam logic [1:0] STB_CBR  = 2'b00;

    // Column for a burst beat: wraps inside the open page, never carries into the row
    function automatic logic [31:0] col_wrap(input logic [31:0] col,
                                             input logic [31:0] beat,
                                             input int unsigned addr_w);
        logic [31:0] mask;
        mask = (addr_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << addr_w) - 32'd1);
        return (col + beat) & mask;
    endfunction

endpackage

// File: rtl/dram_refresh_ctr.sv
// dram_refresh_ctr: CBR refresh-row counter plus saturating cycles-since-refresh counter
// Latency: counters update on the edge that samples cbr; refresh_due follows the counter
// Backpressure: none, refresh_due is advisory only
`ifdef DRAM_REFRESH_EN
module dram_refresh_ctr
#(
    parameter int ADDR_W           = 8,
    parameter int REFRESH_INTERVAL = 256
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              cbr,
    output logic [ADDR_W-1:0] refresh_row,
    output logic              refresh_due
);

    // Wide enough to hold REFRESH_INTERVAL itself, so the threshold is reachable before saturation
    localparam int CNT_W = $clog2(REFRESH_INTERVAL + 1);

    logic [CNT_W-1:0] since_q;

    // Advance the refresh row on every CBR; count idle cycles, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_row <= '0;
            since_q     <= '0;
        end else if (cbr) begin
            refresh_row <= refresh_row + ADDR_W'(1);
            since_q     <= '0;
        end else if (since_q != {CNT_W{1'b1}}) begin
            since_q     <= since_q + CNT_W'(1);
        end
    end

    assign refresh_due = (since_q >= CNT_W'(REFRESH_INTERVAL));

endmodule
`endif

// File: rtl/dram_burst_ram.sv
// dram_burst_ram: multiplexed-address page-mode RAM with wrapping bursts; DRAM_REFRESH_EN adds CBR refresh tracking
// Latency: read beat k valid in the cycle after edge CAS+1+k; write beat k stored at edge CAS+k
// Backpressure: strobes sampled while busy are dropped; enable low aborts to IDLE
module dram_burst_ram
    import dram_pkg::*;
#(
    parameter int DATA_W           = 8,
    parameter int ADDR_W           = 8,
    parameter int BURST_LEN        = 1,
    parameter int REFRESH_INTERVAL = 256
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              ras_b,
    input  logic              cas_b,
    input  logic              read,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              page_open,
    output logic              refresh_due
);

    localparam int                DEPTH     = 1 << (2 * ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BURST_LEN - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   row_q;
    logic [ADDR_W-1:0]   col_q;
    logic [ADDR_W-1:0]   beat_q;
    logic [ADDR_W-1:0]   beat_col;
    logic [1:0]          strobe;
    logic                last_beat;
    logic                wr_en;
    logic [2*ADDR_W-1:0] wr_addr;
    logic [2*ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign strobe    = {ras_b, cas_b};
    assign beat_col  = ADDR_W'(col_wrap(32'(col_q), 32'(beat_q), ADDR_W));
    assign last_beat = (beat_q == LAST_BEAT);
    assign rd_addr   = {row_q, beat_col};
    assign busy      = (state_q == ST_BURST_RD) || (state_q == ST_BURST_WR);
    assign page_open = (state_q != ST_IDLE);

    // Write port: beat 0 lands in the CAS cycle itself using the live column, later beats use the wrapped column
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (!rst && enable) begin
            if (state_q == ST_PAGE && strobe == STB_CAS && !read) begin
                wr_en   = 1'b1;
                wr_addr = {row_q, addr};
            end else if (state_q == ST_BURST_WR) begin
                wr_en   = 1'b1;
                wr_addr = rd_addr;
            end
        end
    end

    // Storage array: no reset, contents survive rst and enable drops
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= data_in;
        end
    end

    // Page/burst sequencing and registered read data; enable low overrides every state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            beat_q     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (!enable) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (strobe == STB_RAS) begin
                            row_q   <= addr;
                            state_q <= ST_PAGE;
                        end
                    end
                    ST_PAGE: begin
                        if (strobe == STB_RAS) begin
                            row_q <= addr;
                        end else if (strobe == STB_CAS) begin
                            col_q <= addr;
                            if (read) begin
                                beat_q  <= '0;
                                state_q <= ST_BURST_RD;
                            end else if (BURST_LEN > 1) begin
                                // Beat 0 was already written this cycle, so the burst resumes at beat 1
                                beat_q  <= ADDR_W'(1);
                                state_q <= ST_BURST_WR;
                            end
                        end
                    end
                    ST_BURST_RD: begin
                        data_out   <= mem[rd_addr];
                        data_valid <= 1'b1;
                        beat_q     <= beat_q + ADDR_W'(1);
                        if (last_beat) begin
                            state_q <= ST_PAGE;
                        end
                    end
                    ST_BURST_WR: begin
                        beat_q <= beat_q + ADDR_W'(1);
                        if (last_beat) begin
                            state_q <= ST_PAGE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef DRAM_REFRESH_EN
    logic              cbr;
    logic [ADDR_W-1:0] refresh_row;

    // CAS-before-RAS only counts as a refresh from IDLE with the device enabled
    assign cbr = enable && (state_q == ST_IDLE) && (strobe == STB_CBR);

    dram_refresh_ctr #(
        .ADDR_W           (ADDR_W),
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh (
        .clk         (clk),
        .rst         (rst),
        .cbr         (cbr),
        .refresh_row (refresh_row),
        .refresh_due (refresh_due)
    );
`else
    assign refresh_due = 1'b0;
`endif

endmodule
